map_collide: RTL

Map collision reader for the overworld. On request it reads back the 256x176 map memory that the map draw block writes to the screen. It scans a BOX_W x BOX_H rectangle at a given screen coordinate in row-major order and reports whether any pixel carries a blocking colour. Control/player logic issues a check before committing a move; the block owns a read port on the map memory.

---
 rtl/map_collide_if.sv | 22 ++
 rtl/map_collide.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/map_collide_if.sv
// Request/result handshake and map-memory read port of the collision reader.
// The slave modport is the collision block; master is the requester plus the map memory.
interface map_collide_if;
  logic        req;
  logic [8:0]  query_x;
  logic [7:0]  query_y;
  logic        busy;
  logic        done;
  logic        blocked;
  logic [15:0] mem_addr;
  logic [5:0]  mem_q;

  modport slave (
    input  req, query_x, query_y, mem_q,
    output busy, done, blocked, mem_addr
  );

  modport master (
    output req, query_x, query_y, mem_q,
    input  busy, done, blocked, mem_addr
  );
endinterface

// File: rtl/map_collide.sv
// Scans a BOX_W x BOX_H map window row-major for blocking colours; done after N+3 cycles when clear,
// 4+k when pixel k blocks, 2 when out of bounds. req is ignored while busy; nothing is queued.
module map_collide #(
  parameter int         X_INITIAL    = 31,
  parameter int         Y_INITIAL    = 31,
  parameter int         MAP_W        = 256,
  parameter int         MAP_H        = 176,
  parameter int         BOX_W        = 16,
  parameter int         BOX_H        = 16,
  parameter logic [5:0] WALL_COLOUR  = 6'h15,
  parameter logic [5:0] WATER_COLOUR = 6'h0B
) (
  input  logic         clock,
  input  logic         reset,
  map_collide_if.slave bus
);

  localparam int CW = (BOX_W > 1) ? $clog2(BOX_W) : 1;
  localparam int RW = (BOX_H > 1) ? $clog2(BOX_H) : 1;

  typedef enum logic [2:0] {IDLE, CHECK, SCAN, DRAIN, DONE} state_t;

  state_t          state_q;
  logic [8:0]      qx_q;
  logic [7:0]      qy_q;
  logic [7:0]      x_base_q;
  logic [7:0]      y_base_q;
  logic [CW-1:0]   col_q;
  logic [RW-1:0]   row_q;
  logic            vld_q;
  logic            busy_q;
  logic            done_q;
  logic            blocked_q;
  logic [15:0]     mem_addr_q;

  logic [9:0]      x_rel;
  logic [9:0]      y_rel;
  logic            oob;
  logic            col_wrap;
  logic            last;
  logic            hit;
  logic [CW-1:0]   col_d;
  logic [RW-1:0]   row_d;
  logic [15:0]     addr_d;

  // Relative offsets are 10 bits so a query left of/above the map wraps harmlessly; the
  // explicit less-than tests catch that case before the sum tests are trusted.
  assign x_rel = {1'b0, qx_q} - 10'(X_INITIAL);
  assign y_rel = {2'b00, qy_q} - 10'(Y_INITIAL);
  assign oob   = (qx_q < 9'(X_INITIAL)) || (qy_q < 8'(Y_INITIAL)) ||
                 (({1'b0, x_rel} + 11'(BOX_W)) > 11'(MAP_W)) ||
                 (({1'b0, y_rel} + 11'(BOX_H)) > 11'(MAP_H));

  assign col_wrap = (col_q == CW'(BOX_W - 1));
  assign last     = col_wrap && (row_q == RW'(BOX_H - 1));
  assign col_d    = col_wrap ? '0 : col_q + CW'(1);
  assign row_d    = col_wrap ? row_q + RW'(1) : row_q;
  assign addr_d   = {y_base_q + 8'(row_d), x_base_q + 8'(col_d)};
  assign hit      = vld_q && ((bus.mem_q == WALL_COLOUR) || (bus.mem_q == WATER_COLOUR));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      qx_q       <= '0;
      qy_q       <= '0;
      x_base_q   <= '0;
      y_base_q   <= '0;
      col_q      <= '0;
      row_q      <= '0;
      vld_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      blocked_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      done_q <= 1'b0;
      vld_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req) begin
            qx_q      <= bus.query_x;
            qy_q      <= bus.query_y;
            blocked_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= CHECK;
          end
        end
        CHECK: begin
          if (oob) begin
            blocked_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end else begin
            col_q      <= '0;
            row_q      <= '0;
            x_base_q   <= x_rel[7:0];
            y_base_q   <= y_rel[7:0];
            mem_addr_q <= {y_rel[7:0], x_rel[7:0]};
            state_q    <= SCAN;
          end
        end
        SCAN: begin
          // On a hit the address already issued is abandoned and mem_addr freezes on it.
          if (hit) begin
            blocked_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end else begin
            vld_q <= 1'b1;
            if (last) begin
              state_q <= DRAIN;
            end else begin
              col_q      <= col_d;
              row_q      <= row_d;
              mem_addr_q <= addr_d;
            end
          end
        end
        DRAIN: begin
          if (hit) begin
            blocked_q <= 1'b1;
          end
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.blocked  = blocked_q;
  assign bus.mem_addr = mem_addr_q;

endmodule
